// File: rtl/ps2_event_rx.sv
// PS/2 keyboard receiver: synchronises the raw pins, deserialises 11-bit frames,
// folds the 0xF0 break prefix into each key event and queues {break, code} words.
module ps2_event_rx #(
  parameter int FIFO_DEPTH     = 8,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       clrn,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [8:0] data,
  output logic       ready,
  input  logic       nextdata_n,
  output logic       overflow,
  output logic       frame_err
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int IW = $clog2(TIMEOUT_CYCLES + 1);

  typedef struct packed {
    logic       brk;
    logic [7:0] code;
  } kev_t;

  // ---------------- pin synchronisers (idle-high reset) ----------------
  logic [1:0] kclk_sync;
  logic       kclk_hist;
  logic [1:0] kdat_sync;
  logic       fall;

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      kclk_sync <= 2'b11;
      kclk_hist <= 1'b1;
      kdat_sync <= 2'b11;
    end else begin
      kclk_sync <= {kclk_sync[0], ps2_clk};
      kclk_hist <= kclk_sync[1];
      kdat_sync <= {kdat_sync[0], ps2_data};
    end
  end

  assign fall = kclk_hist & ~kclk_sync[1];

  // ---------------- frame receiver ----------------
  logic [3:0]    bit_cnt;
  logic [10:0]   shreg;
  logic [10:0]   frame;
  logic          frame_ok;
  logic [IW-1:0] idle_cnt;
  logic          byte_stb;
  logic [7:0]    rx_byte;

  // frame as it will look once the bit arriving on this edge is shifted in
  assign frame    = {kdat_sync[1], shreg[10:1]};
  assign frame_ok = ~frame[0] & frame[10] & (^frame[9:1]);

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      bit_cnt   <= '0;
      shreg     <= '0;
      idle_cnt  <= '0;
      byte_stb  <= 1'b0;
      rx_byte   <= '0;
      frame_err <= 1'b0;
    end else begin
      byte_stb  <= 1'b0;
      frame_err <= 1'b0;
      if (fall) begin
        idle_cnt <= '0;
        shreg    <= frame;
        if (bit_cnt == 4'd10) begin
          bit_cnt <= '0;
          if (frame_ok) begin
            byte_stb <= 1'b1;
            rx_byte  <= frame[8:1];
          end else begin
            frame_err <= 1'b1;
          end
        end else begin
          bit_cnt <= bit_cnt + 4'd1;
        end
      end else if (bit_cnt != 4'd0) begin
        // stalled partial frame is dropped without an error pulse
        if (idle_cnt == IW'(TIMEOUT_CYCLES - 1)) begin
          bit_cnt  <= '0;
          idle_cnt <= '0;
        end else begin
          idle_cnt <= idle_cnt + 1'b1;
        end
      end else begin
        idle_cnt <= '0;
      end
    end
  end

  // ---------------- break/extend decoder ----------------
  logic brk_pend;
  logic push;
  kev_t push_ev;

  always_comb begin
    push    = 1'b0;
    push_ev = '0;
    if (byte_stb && rx_byte != 8'hF0 && rx_byte != 8'hE0) begin
      push    = 1'b1;
      push_ev = '{brk: brk_pend, code: rx_byte};
    end
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      brk_pend <= 1'b0;
    end else if (byte_stb) begin
      if (rx_byte == 8'hF0)
        brk_pend <= 1'b1;
      else if (rx_byte != 8'hE0)
        brk_pend <= 1'b0;
    end
  end

  // ---------------- show-ahead event FIFO ----------------
  logic [AW:0] wr_ptr, rd_ptr;
  kev_t        mem [FIFO_DEPTH];
  logic        empty, full, pop, wr_en;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop   = ~nextdata_n & ~empty;
  // a pop frees the head slot in the same cycle, so a full FIFO can still accept
  assign wr_en = push & (~full | pop);

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      overflow <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
      if (push && full && !pop) overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr[AW-1:0]] <= push_ev;
  end

  assign ready = ~empty;
  assign data  = empty ? 9'h000 : mem[rd_ptr[AW-1:0]];

endmodule
